bcd_seq: RTL and testbench
==========================

BCD_SEQ -- requirements
Module: bcd_seq

Interface
REQ-001 Parameter: SAT_VAL, default 999, meaning magnitude clamp value; it SHALL be a legal 3-digit decimal value.
REQ-002 Port: clk  input  1  meaning rising-edge system clock, the only clock.
REQ-003 Port: rst_n  input  1  meaning asynchronous, active-low reset.
REQ-004 Port: start  input  1  meaning request conversion of bin; accepted only while ready=1.
REQ-005 Port: bin  input  11  meaning signed two's-complement operand, -1024..1023.
REQ-006 Port: ready  output  1  meaning block idle, able to accept start.
REQ-007 Port: valid  output  1  meaning one-cycle pulse marking new result on bcd/neg/sat.
REQ-008 Port: bcd  output  12  meaning [3:0] ones, [7:4] tens, [11:8] hundreds, each 0..9.
REQ-009 Port: neg  output  1  meaning sign of the converted operand.
REQ-010 Port: sat  output  1  meaning operand magnitude exceeded SAT_VAL and was clamped.

Function
REQ-011 The block SHALL use one clock and an asynchronous, active-low reset; clk and rst_n SHALL be the only clock and reset.
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, ready SHALL be 1; in SHIFT and DONE it SHALL be 0.
REQ-014 When start=1 and ready=1 at a clock edge (acceptance edge E0), the block SHALL capture the magnitude |bin| into a 10-bit shift register and capture neg_i = bin[10].
REQ-015 At acceptance, it SHALL capture sat_i = (|bin| > SAT_VAL) and replace the magnitude with SAT_VAL when sat_i=1.
REQ-016 |-1024| SHALL be computed in 11 bits and saturate.
REQ-017 After E0 the state SHALL be SHIFT, and a 4-bit iteration counter SHALL be cleared to 0.
REQ-018 Each SHIFT edge SHALL apply double-dabble: add 3 to every BCD digit >= 5, then shift {bcd_acc, mag} left by 1 bit, then increment the counter.
REQ-019 SHIFT SHALL run for exactly 10 edges (E1..E10).
REQ-020 At E10 the state SHALL move to DONE and bcd, neg, sat SHALL load from bcd_acc, neg_i and sat_i.
REQ-021 neg SHALL load as 0 when the result is 0.
REQ-022 In DONE, valid SHALL be 1 for exactly one cycle, ready SHALL be 0, and the state SHALL move to IDLE at the next edge (E11).
REQ-023 Latency SHALL be 11 edges from acceptance to the cycle in which valid=1.
REQ-024 The acceptance-to-acceptance period SHALL be at least 12 cycles.
REQ-025 start while ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-026 bin SHALL be sampled only at the acceptance edge; later changes to bin SHALL have no effect on the conversion in flight.
REQ-027 bcd, neg and sat SHALL hold their last result until the next DONE.
REQ-028 valid SHALL be 0 in all states except DONE.
REQ-029 Every bcd digit SHALL be in the range 0..9 at all times.
REQ-030 An internal add-3 carry SHALL NOT overflow a digit.

Reset
REQ-031 While rst_n=0, regardless of clk: state IDLE, ready=1, valid=0, bcd=12'h000, neg=0, sat=0, counter=0, shift registers=0.
REQ-032 Reset asserted mid-conversion SHALL abort the conversion with no valid pulse, and outputs SHALL take their reset values.
REQ-033 The first acceptance after reset release SHALL be possible at the first rising edge with rst_n=1.

Verification
REQ-034 Scenario: bin=0, start pulse -> valid 11 edges later; bcd=12'h000, neg=0, sat=0.
REQ-035 Scenario: bin=-537 -> bcd=12'h537, neg=1, sat=0.
REQ-036 Scenario: bin=999 -> bcd=12'h999, sat=0.
REQ-037 Scenario: bin=1023 -> bcd=12'h999, neg=0, sat=1; then bin=-1024 -> bcd=12'h999, neg=1, sat=1.
REQ-038 Scenario: accept bin=42; at E3 drive bin=-7 with start=1 -> single valid with bcd=12'h042, neg=0, and no second result.
REQ-039 Scenario: accept bin=250; rst_n=0 at E5 -> ready=1, bcd=12'h000, no valid.
REQ-040 Scenario (reset follow-up): after rst_n release, bin=-1 -> bcd=12'h001, neg=1.
REQ-041 Scenario: start held high with bin=7 -> valid every 12 cycles, bcd=12'h007 each time.
REQ-042 A bench SHALL check REQ-029 and REQ-028 continuously.
REQ-043 A bench SHALL sweep all 2048 bin values against a reference model of |clamp(bin)| digits.

Source files
------------

// File: rtl/bcd_seq_if.sv
// Handshake and result bus of the signed binary-to-BCD converter.
interface bcd_seq_if;
  logic        start;
  logic [10:0] bin;
  logic        ready;
  logic        valid;
  logic [11:0] bcd;
  logic        neg;
  logic        sat;

  modport master (output start, bin, input ready, valid, bcd, neg, sat);
  modport slave  (input start, bin, output ready, valid, bcd, neg, sat);
endinterface

// File: rtl/bcd_seq.sv
// Sequential signed binary to 3-digit BCD converter (double-dabble).
// Accepts an 11-bit two's-complement operand, clamps its magnitude to
// SAT_VAL and produces sign, saturation flag and BCD digits 11 edges later.
module bcd_seq #(
  parameter int SAT_VAL = 999
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [10:0] SAT_L = 11'(SAT_VAL);

  state_t      state;
  logic [3:0]  cnt;
  logic [9:0]  mag;
  logic [11:0] bcd_acc;
  logic        neg_i;
  logic        sat_i;

  logic        ready_r;
  logic        valid_r;
  logic [11:0] bcd_r;
  logic        neg_r;
  logic        sat_r;

  logic [10:0] abs_bin;
  logic        acc_sat;
  logic [9:0]  mag_in;
  logic [11:0] adj;
  logic [21:0] shifted;
  logic [11:0] bcd_next;
  logic [9:0]  mag_next;

  assign bus.ready = ready_r;
  assign bus.valid = valid_r;
  assign bus.bcd   = bcd_r;
  assign bus.neg   = neg_r;
  assign bus.sat   = sat_r;

  // Magnitude in 11 bits so that -1024 yields 1024 and saturates.
  always_comb begin
    abs_bin = bus.bin[10] ? (~bus.bin + 11'd1) : bus.bin;
    acc_sat = (abs_bin > SAT_L);
    mag_in  = acc_sat ? SAT_L[9:0] : abs_bin[9:0];
  end

  // Add-3 correction on each digit that would overflow when doubled.
  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    assign adj[gi*4 +: 4] = (bcd_acc[gi*4 +: 4] >= 4'd5) ?
                            (bcd_acc[gi*4 +: 4] + 4'd3) : bcd_acc[gi*4 +: 4];
  end

  // One double-dabble step: shift the corrected digits and magnitude together.
  always_comb begin
    shifted  = {adj, mag} << 1;
    bcd_next = shifted[21:10];
    mag_next = shifted[9:0];
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      mag     <= 10'd0;
      bcd_acc <= 12'h000;
      neg_i   <= 1'b0;
      sat_i   <= 1'b0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      bcd_r   <= 12'h000;
      neg_r   <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= SHIFT;
            ready_r <= 1'b0;
            mag     <= mag_in;
            neg_i   <= bus.bin[10];
            sat_i   <= acc_sat;
            bcd_acc <= 12'h000;
            cnt     <= 4'd0;
          end
        end
        SHIFT: begin
          bcd_acc <= bcd_next;
          mag     <= mag_next;
          cnt     <= cnt + 4'd1;
          // Tenth step: publish the finished digits; a zero result is never negative.
          if (cnt == 4'd9) begin
            state   <= DONE;
            bcd_r   <= bcd_next;
            neg_r   <= neg_i && (bcd_next != 12'h000);
            sat_r   <= sat_i;
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq.sv
// Self-checking bench for bcd_seq: directed scenarios, randomized operands
// with in-flight noise, and a full sweep against an arithmetic reference.
module tb_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_seq_if bus ();

  bcd_seq #(.SAT_VAL(999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: clamp |b| to 999 and split into decimal digits.
  task automatic ref_model(input int b, output logic [11:0] eb, output logic en, output logic es);
    int m;
    m  = (b < 0) ? -b : b;
    es = (m > 999);
    if (es) m = 999;
    eb = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    en = (b < 0) && (m != 0);
  endtask

  // Continuous checks: legal digits, valid only while busy, valid never two cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("digit_range", {31'd0, (bus.bcd[3:0] <= 4'd9) && (bus.bcd[7:4] <= 4'd9) &&
                                 (bus.bcd[11:8] <= 4'd9)}, 32'd1);
      chk("valid_not_ready", {31'd0, !(bus.valid && bus.ready)}, 32'd1);
      chk("valid_one_cycle", {31'd0, !(bus.valid && prev_valid)}, 32'd1);
      if (bus.valid) vcount++;
      prev_valid = bus.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_start", {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic convert(input int b, input bit noise);
    logic [11:0] eb;
    logic en, es;
    int lat, v0;
    ref_model(b, eb, en, es);
    wait_ready();
    bus.start = 1'b1;
    bus.bin   = 11'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    v0  = vcount;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      lat = k;
      if (bus.valid) break;
      if (noise) begin
        bus.bin   = 11'($urandom);
        bus.start = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    chk("latency", lat, 32'd11);
    chk("bcd", {20'd0, bus.bcd}, {20'd0, eb});
    chk("neg", {31'd0, bus.neg}, {31'd0, en});
    chk("sat", {31'd0, bus.sat}, {31'd0, es});
    @(negedge clk);
    chk("valid_cleared", {31'd0, bus.valid}, 32'd0);
    chk("single_valid", vcount - v0, 32'd1);
    chk("bcd_hold", {20'd0, bus.bcd}, {20'd0, eb});
    $display("conv bin=%0d bcd=%03h neg=%0b sat=%0b lat=%0d", b, bus.bcd, bus.neg, bus.sat, lat);
  endtask

  initial begin
    int lat, v0, n;
    int times [3];

    bus.start = 1'b0;
    bus.bin   = 11'd0;

    // Reset state while rst_n is low.
    #12;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_bcd", {20'd0, bus.bcd}, 32'd0);
    chk("rst_neg", {31'd0, bus.neg}, 32'd0);
    chk("rst_sat", {31'd0, bus.sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values, the first accepted at the first edge after release.
    convert(0, 0);
    convert(-537, 0);
    convert(999, 0);
    convert(1023, 0);
    convert(-1024, 0);

    // Start while busy is ignored and bin is sampled only at acceptance.
    wait_ready();
    bus.start = 1'b1;
    bus.bin   = 11'd42;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    v0  = vcount;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      lat = k;
      if (bus.valid) break;
      if (k == 3) begin
        bus.start = 1'b1;
        bus.bin   = -11'sd7;
      end
    end
    bus.start = 1'b0;
    chk("busy_latency", lat, 32'd11);
    chk("busy_bcd", {20'd0, bus.bcd}, 32'h042);
    chk("busy_neg", {31'd0, bus.neg}, 32'd0);
    repeat (15) @(negedge clk);
    chk("no_queued", vcount - v0, 32'd1);
    $display("busy-start bin=42 bcd=%03h results=%0d", bus.bcd, vcount - v0);

    // Reset in flight aborts the conversion.
    wait_ready();
    bus.start = 1'b1;
    bus.bin   = 11'd250;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    v0 = vcount;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'd0, bus.ready}, 32'd1);
    chk("abort_valid", {31'd0, bus.valid}, 32'd0);
    chk("abort_bcd", {20'd0, bus.bcd}, 32'd0);
    chk("abort_neg", {31'd0, bus.neg}, 32'd0);
    chk("abort_sat", {31'd0, bus.sat}, 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_valid", vcount - v0, 32'd0);
    $display("abort bin=250 ready=%0b bcd=%03h", bus.ready, bus.bcd);
    rst_n = 1'b1;
    convert(-1, 0);

    // Start held high: back-to-back results every 12 cycles.
    wait_ready();
    bus.start = 1'b1;
    bus.bin   = 11'd7;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (bus.valid) begin
        times[n] = c;
        chk("held_bcd", {20'd0, bus.bcd}, 32'h007);
        n++;
        if (n == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("held_count", n, 32'd3);
    if (n == 3) begin
      chk("held_period1", times[1] - times[0], 32'd12);
      chk("held_period2", times[2] - times[1], 32'd12);
    end
    $display("held-start results=%0d", n);

    // Random operands with noise on bin/start during the conversion.
    repeat (30) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert(int'($urandom_range(0, 2047)) - 1024, 1);
    end

    // Exhaustive sweep of every operand.
    for (int b = -1024; b < 1024; b++) convert(b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
